// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch FSM state type and opcode field constants.
package cpu_pkg;
    typedef enum logic [2:0] {FETCH, LATCH, ISSUE, HALTED, FAULT} fetch_state_t;
    localparam logic [5:0] HALT_OPCODE = 6'b111111;
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction memory and fetch/execute handshake bundle.
interface instr_fetch_if #(parameter int ADDR_W = 32);
    logic [ADDR_W-1:0] imem_addr;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] next_pc;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic instr_valid;
    logic exec_done;
    modport master (output imem_addr, pc, instr, instr_valid, input imem_rdata, exec_done, next_pc);
    modport slave (input imem_addr, pc, instr, instr_valid, output imem_rdata, exec_done, next_pc);
endinterface

// File: rtl/pc_register.sv
// pc_register: loadable program counter with async reset to RESET_PC.
module pc_register #(
    parameter int ADDR_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] d,
    output logic [ADDR_W-1:0] q
);
    logic [ADDR_W-1:0] q_d;
    always_comb q_d = load ? d : q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= RESET_PC;
        else q <= q_d;
    end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: multi-cycle fetch stage owning the PC; stops on halt opcode or misaligned next_pc.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [5:0] HALT_OPCODE = cpu_pkg::HALT_OPCODE
) (
    input  logic        clk,
    input  logic        rst_n,
    instr_fetch_if.master bus,
    output logic        halted,
    output logic        pc_fault,
    output logic [31:0] retired
);
    fetch_state_t state_q, state_d;
    logic [31:0] instr_q, instr_d, retired_q, retired_d;
    logic valid_q, valid_d, halted_q, halted_d, fault_q, fault_d;
    logic accept, is_halt, misaligned;
    logic [ADDR_W-1:0] pc_q;
    pc_register #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
        .clk(clk), .rst_n(rst_n), .load(accept), .d(bus.next_pc), .q(pc_q)
    );
    always_comb begin
        accept = state_q == ISSUE && bus.exec_done;
        is_halt = bus.imem_rdata[OPC_HI:OPC_LO] == HALT_OPCODE;
        misaligned = bus.next_pc[1:0] != 2'b00;
        state_d = state_q;
        instr_d = state_q == LATCH ? bus.imem_rdata : instr_q;
        valid_d = valid_q;
        halted_d = halted_q;
        fault_d = fault_q;
        retired_d = retired_q;
        case (state_q)
            FETCH: state_d = LATCH;
            LATCH: begin
                state_d = is_halt ? HALTED : ISSUE;
                halted_d = is_halt;
                valid_d = !is_halt;
            end
            ISSUE: if (accept) begin
                state_d = misaligned ? FAULT : FETCH;
                fault_d = misaligned;
                valid_d = 1'b0;
                retired_d = retired_q + 32'(retired_q != '1);
            end
            default: ;
        endcase
    end
    // Terminal states simply hold: only reset leaves HALTED or FAULT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            instr_q <= '0;
            valid_q <= 1'b0;
            halted_q <= 1'b0;
            fault_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            halted_q <= halted_d;
            fault_q <= fault_d;
            retired_q <= retired_d;
        end
    end
    assign bus.imem_addr = pc_q;
    assign bus.pc = pc_q;
    assign bus.instr = instr_q;
    assign bus.instr_valid = valid_q;
    assign halted = halted_q;
    assign pc_fault = fault_q;
    assign retired = retired_q;
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Multi-cycle instruction fetch stage that owns the architectural program counter, reads the instruction memory and hands one instruction at a time to decode/execute. It sits directly upstream of the branching unit. It supplies `pc` to the branching unit and consumes the unit's `next_pc` when the current instruction completes. It also detects halt and misaligned-PC conditions.

## Interface
Parameters:
- `ADDR_W`, 32: PC / instruction-memory address width.
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `HALT_OPCODE`, 6'b111111: value of `instr[31:26]` that stops fetching.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `imem_addr`  out  ADDR_W: instruction-memory read address (synchronous memory; data returns one cycle later).
- `imem_rdata`  in  32: instruction-memory read data.
- `pc`  out  ADDR_W: address of the instruction currently held in `instr`; feeds the branching unit.
- `instr`  out  32: instruction register.
- `instr_valid`  out  1: `instr`/`pc` hold an instruction awaiting execution.
- `exec_done`  in  1: execute has finished the issued instruction; `next_pc` is valid this cycle.
- `next_pc`  in  ADDR_W: next PC from the branching unit (PC+4 or branch/jump target).
- `halted`  out  1: fetch stopped on a halt instruction.
- `pc_fault`  out  1: fetch stopped on a misaligned `next_pc`.
- `retired`  out  32: count of instructions completed (`exec_done` accepted).

## Operation
- FSM states: FETCH, LATCH, ISSUE, HALTED, FAULT.
- On reset:
  - State goes to FETCH; `pc` = `RESET_PC` and `imem_addr` = `RESET_PC`.
  - `instr`=0, `instr_valid`=0, `halted`=0, `pc_fault`=0, `retired`=0.
- FETCH:
  - `imem_addr` = `pc`; go to LATCH.
- LATCH:
  - Capture `imem_rdata` into `instr`.
  - If `imem_rdata[31:26]` == `HALT_OPCODE`, go to HALTED. Otherwise go to ISSUE.
- ISSUE:
  - `instr_valid`=1 and holds until `exec_done`.
  - On `exec_done`: `pc`<=`next_pc` and `retired`<=`retired`+1, saturating at 32'hFFFF_FFFF.
  - If `next_pc[1:0]`!=0, go to FAULT with `pc` still loaded with the bad value. Otherwise go to FETCH.
- HALTED:
  - `halted`=1 and `instr_valid`=0.
  - `pc` stays at the halt instruction's address. Left only by reset.
- FAULT:
  - `pc_fault`=1 and `instr_valid`=0. Left only by reset.
- `exec_done` outside ISSUE is ignored; `next_pc` is sampled only on accepted `exec_done`.
- `imem_addr` always equals `pc` (registered); it is not combinationally derived from `next_pc`.
- PC arithmetic is performed by the branching unit; this block never increments `pc` itself.
- A halt instruction never raises `instr_valid` and is not counted in `retired`.

## Timing
- Reset release → `imem_addr` valid immediately (cycle 0, state FETCH).
- First instruction is in LATCH at cycle 1 and `instr_valid`=1 from cycle 2.
- Latency from `exec_done` to the next `instr_valid`: 3 cycles (FETCH, LATCH, ISSUE).
- Minimum cycles per instruction: 3.
- `exec_done` in the same cycle `instr_valid` first rises is legal and accepted.
- `instr_valid` falls in the cycle after `exec_done` is accepted.
- All outputs are registered; none depends combinationally on inputs.
- Asynchronous `rst_n` assertion mid-ISSUE:
  - Outputs go to their reset values immediately.
  - The pending `exec_done` is lost and `retired` is not incremented.
- `halted` and `pc_fault` are never both 1.

## Structure
- Shared package `cpu_pkg`:
  - State enum `fetch_state_t`.
  - `HALT_OPCODE`.
  - Opcode field slice constants `OPC_HI`=31 and `OPC_LO`=26, shared with decode.
- Sub-module `pc_register`: `ADDR_W`-bit register with async active-low reset to `RESET_PC` and a load enable. It is instantiated once for `pc`; the FSM, instruction register and counter live in `instr_fetch`.

## Test plan
- Reset, then memory word at 0 = 32'h0000_1234: `instr_valid`=1 at cycle 2, `instr`=32'h0000_1234, `pc`=0, `retired`=0.
- Sequential run: `exec_done` with `next_pc`=4, then 8: `imem_addr` steps 0→4→8, `retired`=2, 3 cycles between `instr_valid` rises.
- Taken branch: at `pc`=100, `exec_done` with `next_pc`=10000: `imem_addr`=10000 next cycle, `pc`=10000 at the following issue.
- Halt: word at 8 = 32'hFC00_0000: `halted`=1 after LATCH, `instr_valid` stays 0, `pc`=8, `retired` unchanged, later `exec_done` ignored.
- Fault: `exec_done` with `next_pc`=102: `pc_fault`=1, `pc`=102, no further fetch.
- Reset mid-ISSUE with `exec_done` high: `pc`=`RESET_PC`, `instr_valid`=0, `retired`=0 asynchronously; fetch restarts at 0 after release.
